alu_cmd_rx: RTL
===============

# alu_cmd_rx

Serial command receiver for the ALU input port. It deframes the `sin` bitstream into 11-bit frames. It then assembles eight DATA frames and one CMD frame into operands `B`, `A` and an opcode. It checks CRC4 and reports a single result strobe with decoded operands or one error class. It sits between the `sin` pin and the ALU datapath, and is the receiving end of the stimulus protocol the testbench drives.

## Interface
- `CRC_INIT`, default 4'h0: CRC4 seed.
- `clk` in 1: sole clock. `sin` is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sin` in 1: serial input, idle high.
- `out_valid` out 1: one-cycle result strobe.
- `A` out 32: operand A; updated only on a good packet.
- `B` out 32: operand B; updated only on a good packet.
- `op` out 3: opcode; updated only on a good packet.
- `err_data` out 1: framing or count error, valid with `out_valid`.
- `err_crc` out 1: CRC mismatch, valid with `out_valid`.
- `err_op` out 1: unsupported opcode, valid with `out_valid`.
- `busy` out 1: high while a packet is partially received.

## Operation
- **Frame format:** start 0, type bit (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop 1. Total 11 bits, one bit per clock.
- **Packet order:** B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24]…A[7:0], then CMD `{1'b0, op[2:0], crc[3:0]}`.
- **Frame FSM states:** WAIT_IDLE, IDLE, TYPE, DATA(0..7), STOP.
  - WAIT_IDLE: entered from reset. Moves to IDLE only after sampling `sin` = 1, so `sin` held low at reset release is not a start bit.
  - IDLE: `sin` = 0 moves to TYPE.
  - STOP with `sin` = 1: frame accepted.
  - STOP with `sin` = 0: stop error; go to WAIT_IDLE.
- **Packet counter:** 0..8 DATA frames. A 9th DATA frame sets a sticky `overflow` flag.
- **On CMD frame**, exactly one error is flagged, checked in this priority order:
  1. `err_data`: count ≠ 8, `overflow` set, or a stop error anywhere in the packet (including the CMD itself).
  2. `err_crc`: crc ≠ crc4({B, A, 1'b1, op}, CRC_INIT). The polynomial is x^4+x+1 over 68 bits.
  3. `err_op`: op[1] = 1. Only 000 AND, 001 OR, 100 ADD and 101 SUB are legal.
  4. Otherwise the packet is good: load `A`, `B`, `op`.
- After any CMD, the counter, `overflow` and the stop-error flag all clear.
- **Stop error on a DATA frame:** the flag is held and reported as `err_data` at the next CMD. The partial data is discarded.
- **Reset values:** all outputs 0. The FSM enters WAIT_IDLE.
- **Reset mid-packet:** the partial packet is discarded and no strobe is issued.

## Timing
- The frame sub-module pulses `frame_valid` one cycle after the edge that samples the stop bit.
- `out_valid` and the error flags assert exactly 2 cycles after the edge sampling the CMD stop bit, for one cycle only.
- `A`, `B` and `op` change in the same cycle as `out_valid` and then hold.
- Back-to-back frames with no idle bit between them must be accepted: STOP with `sin` = 1, then a start bit on the next cycle.
- `busy` rises with the first start bit of a packet and falls with `out_valid`.

## Configuration
- `ALU_CMD_RX_CRC_EN` defined: CRC check active as described above.
- `ALU_CMD_RX_CRC_EN` undefined: no CRC logic is built and `err_crc` is tied to 0. A packet with a bad CRC and legal op reports as good.

## Structure
- Shared package `alu_pkg` holds:
  - `operation_t` opcode encodings;
  - `DATA_TYPE` = 0 and `CMD_TYPE` = 1;
  - the `crc4_generate` function (68-bit data, 4-bit seed), so bench and RTL use the same function.
- Sub-module `alu_sin_frame_rx` contains the bit-level FSM.
  - Outputs: `frame_valid`, `frame_type`, `frame_byte[7:0]`, `stop_err`.
- `alu_cmd_rx` holds the packet counter, shift registers, CRC check and result register.

## Test plan
- **Good ADD:** B = 0x00000002, A = 0x00000003, op = 100, correct CRC. Expect `out_valid` 2 cycles after the CMD stop bit, with A = 3, B = 2, op = 100 and all errors 0.
- **CRC error:** same packet with crc+1. Expect `err_crc` = 1 only, and A/B/op holding their previous values. With the macro undefined, the same packet is reported as good.
- **Illegal op:** op = 010 with correct CRC. Expect `err_op` = 1 only.
- **Short packet:** 7 DATA frames then CMD. Expect `err_data` = 1.
- **Long packet:** 9 DATA frames then CMD. Expect `err_data` = 1. A following good packet then decodes correctly.
- **Reset and idle handling:**
  - `sin` = 0 held through reset release: no frame is detected until `sin` goes high.
  - `rst_n` pulsed low during the 5th DATA frame: no `out_valid`, then a clean packet decodes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU serial command path: opcodes, frame types and CRC4.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic DATA_TYPE = 1'b0;
    localparam logic CMD_TYPE  = 1'b1;

    // CRC4, polynomial x^4+x+1, data consumed MSB first.
    function automatic logic [3:0] crc4_generate(input logic [67:0] data, input logic [3:0] seed);
        logic [3:0] crc;
        logic       fb;
        crc = seed;
        for (int unsigned i = 0; i < 68; i++) begin
            fb  = crc[3] ^ data[67 - i];
            crc = {crc[2:0], 1'b0};
            if (fb) crc = crc ^ 4'b0011;
        end
        return crc;
    endfunction

endpackage

// File: rtl/alu_sin_frame_rx.sv
// Bit-level deframer: start, type, 8 data bits MSB first, stop; one frame per 11 clocks.
module alu_sin_frame_rx
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    output logic       frame_valid,
    output logic       frame_type,
    output logic [7:0] frame_byte,
    output logic       stop_err,
    output logic       frame_active
);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_TYPE,
        S_DATA,
        S_STOP
    } state_t;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic       type_q;
    logic [7:0] byte_q;
    logic       valid_q;
    logic       stop_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_IDLE;
            bit_cnt_q  <= '0;
            type_q     <= DATA_TYPE;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            stop_err_q <= 1'b0;
            case (state_q)
                S_WAIT_IDLE: if (sin) state_q <= S_IDLE;
                S_IDLE:      if (!sin) state_q <= S_TYPE;
                S_TYPE: begin
                    type_q    <= sin;
                    bit_cnt_q <= '0;
                    state_q   <= S_DATA;
                end
                S_DATA: begin
                    byte_q    <= {byte_q[6:0], sin};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= S_STOP;
                end
                S_STOP: begin
                    // A frame with a bad stop is still reported so the packet layer can flag it.
                    valid_q    <= 1'b1;
                    stop_err_q <= ~sin;
                    state_q    <= sin ? S_IDLE : S_WAIT_IDLE;
                end
                default: state_q <= S_WAIT_IDLE;
            endcase
        end
    end

    assign frame_valid  = valid_q;
    assign frame_type   = type_q;
    assign frame_byte   = byte_q;
    assign stop_err     = stop_err_q;
    assign frame_active = (state_q != S_WAIT_IDLE) && (state_q != S_IDLE);

endmodule

// File: rtl/alu_cmd_rx.sv
// Packet assembler: 8 DATA frames (B then A) plus one CMD frame -> operands, opcode, error class.
// Build option: ALU_CMD_RX_CRC_EN enables the CRC4 check; otherwise err_crc is tied low.
module alu_cmd_rx
    import alu_pkg::*;
#(
    parameter logic [3:0] CRC_INIT = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op,
    output logic        busy
);

    logic       frame_valid;
    logic       frame_type;
    logic [7:0] frame_byte;
    logic       stop_err;
    logic       frame_active;

    alu_sin_frame_rx u_frame (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin          (sin),
        .frame_valid  (frame_valid),
        .frame_type   (frame_type),
        .frame_byte   (frame_byte),
        .stop_err     (stop_err),
        .frame_active (frame_active)
    );

    logic [3:0]  count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        stop_flag_q, stop_flag_d;
    logic [63:0] shreg_q, shreg_d;
    logic        cmd_pend_q, cmd_pend_d;
    logic        cmd_bad_q, cmd_bad_d;
    logic [2:0]  cmd_op_q, cmd_op_d;
    logic        busy_q, busy_d;
    logic        out_valid_q, out_valid_d;
    logic        err_data_q, err_data_d;
    logic        err_crc_q, err_crc_d;
    logic        err_op_q, err_op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        crc_bad;

`ifdef ALU_CMD_RX_CRC_EN
    logic [3:0] cmd_crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmd_crc_q <= '0;
        else if (frame_valid && frame_type == CMD_TYPE) cmd_crc_q <= frame_byte[3:0];
    end

    // The shift register is stable here: the next frame cannot complete for ~10 cycles.
    assign crc_bad = (crc4_generate({shreg_q, 1'b1, cmd_op_q}, CRC_INIT) != cmd_crc_q);
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        stop_flag_d = stop_flag_q;
        shreg_d     = shreg_q;
        cmd_pend_d  = 1'b0;
        cmd_bad_d   = cmd_bad_q;
        cmd_op_d    = cmd_op_q;
        out_valid_d = 1'b0;
        err_data_d  = 1'b0;
        err_crc_d   = 1'b0;
        err_op_d    = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        busy_d      = busy_q | frame_active;

        if (frame_valid) begin
            if (frame_type == CMD_TYPE) begin
                cmd_pend_d  = 1'b1;
                cmd_bad_d   = (count_q != 4'd8) | overflow_q | stop_flag_q | stop_err;
                cmd_op_d    = frame_byte[6:4];
                count_d     = '0;
                overflow_d  = 1'b0;
                stop_flag_d = 1'b0;
            end else if (stop_err) begin
                stop_flag_d = 1'b1;
            end else if (count_q == 4'd8) begin
                overflow_d = 1'b1;
            end else begin
                shreg_d = {shreg_q[55:0], frame_byte};
                count_d = count_q + 4'd1;
            end
        end

        if (cmd_pend_q) begin
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            if (cmd_bad_q) begin
                err_data_d = 1'b1;
            end else if (crc_bad) begin
                err_crc_d = 1'b1;
            end else if (cmd_op_q[1]) begin
                err_op_d = 1'b1;
            end else begin
                b_d  = shreg_q[63:32];
                a_d  = shreg_q[31:0];
                op_d = cmd_op_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            stop_flag_q <= 1'b0;
            shreg_q     <= '0;
            cmd_pend_q  <= 1'b0;
            cmd_bad_q   <= 1'b0;
            cmd_op_q    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_data_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_op_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            stop_flag_q <= stop_flag_d;
            shreg_q     <= shreg_d;
            cmd_pend_q  <= cmd_pend_d;
            cmd_bad_q   <= cmd_bad_d;
            cmd_op_q    <= cmd_op_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            err_data_q  <= err_data_d;
            err_crc_q   <= err_crc_d;
            err_op_q    <= err_op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
        end
    end

    assign out_valid = out_valid_q;
    assign err_data  = err_data_q;
    assign err_crc   = err_crc_q;
    assign err_op    = err_op_q;
    assign A         = a_q;
    assign B         = b_q;
    assign op        = op_q;
    // A packet stays busy from its first start bit until its result strobe.
    assign busy      = busy_q | frame_active;

endmodule
